run_controller: RTL and testbench

//  Parametrised run/reset controller wrapping the pipelined MIPS core. It generates the core reset

---
 rtl/run_controller_pkg.sv | 19 +
 rtl/run_controller_if.sv | 33 +++
 rtl/reset_synchronizer.sv | 27 ++
 rtl/run_controller.sv | 145 ++++++++++++++
 tb/tb_run_controller.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/run_controller_pkg.sv
// ============================================================================
// run_controller_pkg: state encoding shared by the run controller blocks.
// Rev 1.0
// ============================================================================
`default_nettype none

package run_controller_pkg;

    localparam int RC_STATE_W = 2;

    typedef enum logic [RC_STATE_W-1:0] {
        RC_HOLD = 2'd0,
        RC_RUN  = 2'd1,
        RC_DONE = 2'd2
    } rc_state_t;

endpackage

`default_nettype wire

// File: rtl/run_controller_if.sv
// ============================================================================
// run_controller_if: core-facing status/stimulus bundle of the run controller.
// Rev 1.0
// ============================================================================
`default_nettype none

interface run_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
);
    logic             run_en;
    logic [PC_W-1:0]  pc;
    logic             retire;
    logic             core_n_reset;
    logic             running;
    logic             done;
    logic             halted;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output run_en, pc, retire,
        input  core_n_reset, running, done, halted, timeout, cycle_count, retire_count
    );

    modport slave (
        input  run_en, pc, retire,
        output core_n_reset, running, done, halted, timeout, cycle_count, retire_count
    );
endinterface

`default_nettype wire

// File: rtl/reset_synchronizer.sv
// ============================================================================
// reset_synchronizer: async-assert, sync-deassert active-low reset.
// Rev 1.0
// ============================================================================
`default_nettype none

module reset_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    output logic rst_sync_n
);
    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = r_sync[SYNC_STAGES-1];
endmodule

`default_nettype wire

// File: rtl/run_controller.sv
// ============================================================================
// run_controller: core reset sequencing, cycle/retire counting, halt/timeout end.
// Rev 1.0
// ============================================================================
`default_nettype none

module run_controller
    import run_controller_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int RESET_CYCLES = 4,
    parameter int MAX_CYCLES   = 200,
    parameter int STALL_LIMIT  = 8,
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32
) (
    input  logic            clk,
    input  logic            n_reset,
    run_controller_if.slave bus
);
    localparam int c_HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int c_STALL_W = $clog2(STALL_LIMIT);

    logic                 rst_sync_n;
    rc_state_t            r_state,        w_state_nxt;
    logic [c_HOLD_W-1:0]  r_hold_cnt,     w_hold_nxt;
    logic [c_STALL_W-1:0] r_stall_cnt,    w_stall_nxt;
    logic [CNT_W-1:0]     r_cycle_cnt,    w_cycle_nxt;
    logic [CNT_W-1:0]     r_retire_cnt,   w_retire_nxt;
    logic [PC_W-1:0]      r_pc_q;
    logic                 r_core_n_reset, w_core_nxt;
    logic                 r_first_run,    w_first_nxt;
    logic                 r_halted,       w_halted_nxt;
    logic                 r_timeout,      w_timeout_nxt;
    logic                 r_done,         w_done_nxt;
    logic                 w_halt_hit;
    logic                 w_limit_hit;

    reset_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk        (clk),
        .n_reset    (n_reset),
        .rst_sync_n (rst_sync_n)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state        <= RC_HOLD;
            r_hold_cnt     <= '0;
            r_stall_cnt    <= '0;
            r_cycle_cnt    <= '0;
            r_retire_cnt   <= '0;
            r_pc_q         <= '0;
            r_core_n_reset <= 1'b0;
            r_first_run    <= 1'b0;
            r_halted       <= 1'b0;
            r_timeout      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_stall_cnt    <= w_stall_nxt;
            r_cycle_cnt    <= w_cycle_nxt;
            r_retire_cnt   <= w_retire_nxt;
            r_pc_q         <= bus.pc;
            r_core_n_reset <= w_core_nxt;
            r_first_run    <= w_first_nxt;
            r_halted       <= w_halted_nxt;
            r_timeout      <= w_timeout_nxt;
            r_done         <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_stall_nxt   = r_stall_cnt;
        w_cycle_nxt   = r_cycle_cnt;
        w_retire_nxt  = r_retire_cnt;
        w_core_nxt    = r_core_n_reset;
        w_first_nxt   = r_first_run;
        w_halted_nxt  = r_halted;
        w_timeout_nxt = r_timeout;
        w_done_nxt    = r_done;
        w_halt_hit    = 1'b0;
        w_limit_hit   = 1'b0;

        case (r_state)
            RC_HOLD: begin
                if (rst_sync_n) begin
                    if (r_hold_cnt == c_HOLD_W'(RESET_CYCLES - 1)) begin
                        w_core_nxt  = 1'b1;
                        w_first_nxt = 1'b1;
                        w_state_nxt = RC_RUN;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 1'b1;
                    end
                end
            end
            RC_RUN: begin
                w_first_nxt = 1'b0;
                if (bus.run_en) begin
                    w_cycle_nxt = r_cycle_cnt + 1'b1;
                    if (bus.retire && (r_retire_cnt != '1)) begin
                        w_retire_nxt = r_retire_cnt + 1'b1;
                    end
                    // pc_q is stale relative to the core on the first RUN cycle
                    if (r_first_run) begin
                        w_stall_nxt = '0;
                    end else if (bus.pc == r_pc_q) begin
                        w_stall_nxt = r_stall_cnt + 1'b1;
                        w_halt_hit  = (r_stall_cnt == c_STALL_W'(STALL_LIMIT - 2));
                    end else begin
                        w_stall_nxt = '0;
                    end
                    w_limit_hit = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));
                end else begin
                    w_stall_nxt = '0;
                end
                if (w_halt_hit || w_limit_hit) begin
                    w_halted_nxt  = r_halted  | w_halt_hit;
                    w_timeout_nxt = r_timeout | w_limit_hit;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = RC_DONE;
                end
            end
            RC_DONE: begin
            end
            default: begin
                w_state_nxt = RC_HOLD;
            end
        endcase
    end

    assign bus.core_n_reset = r_core_n_reset;
    assign bus.running      = (r_state == RC_RUN);
    assign bus.done         = r_done;
    assign bus.halted       = r_halted;
    assign bus.timeout      = r_timeout;
    assign bus.cycle_count  = r_cycle_cnt;
    assign bus.retire_count = r_retire_cnt;
endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ============================================================================
// tb_run_controller: directed, table-driven checks of run_controller.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_run_controller;
    localparam int PERIOD = 20;

    typedef struct {
        int   n;
        logic en;
        logic inc;
        logic ret;
        int   exp_cyc;
        int   exp_ret;
        logic exp_halt;
        logic exp_done;
    } seg_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] pc_v;
    seg_t segs [9];

    always #(PERIOD/2) clk = ~clk;

    run_controller_if #(.PC_W(32), .CNT_W(32)) bus ();

    run_controller #(
        .SYNC_STAGES  (2),
        .RESET_CYCLES (4),
        .MAX_CYCLES   (200),
        .STALL_LIMIT  (8),
        .PC_W         (32),
        .CNT_W        (32)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic [31:0] p, input logic ret);
        @(negedge clk);
        bus.run_en = en;
        bus.pc     = p;
        bus.retire = ret;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " core_n_reset"}, 64'(bus.core_n_reset), 64'd0);
        chk({tag, " running"},      64'(bus.running),      64'd0);
        chk({tag, " done"},         64'(bus.done),         64'd0);
        chk({tag, " halted"},       64'(bus.halted),       64'd0);
        chk({tag, " timeout"},      64'(bus.timeout),      64'd0);
        chk({tag, " cycle_count"},  64'(bus.cycle_count),  64'd0);
        chk({tag, " retire_count"}, 64'(bus.retire_count), 64'd0);
    endtask

    // Hold reset, check the cleared state, release at a negedge and watch the 6-edge sequence.
    task automatic reset_and_release(input string tag);
        n_reset    = 1'b0;
        bus.run_en = 1'b1;
        bus.pc     = '0;
        bus.retire = 1'b0;
        pc_v       = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle({tag, " in reset"});
        @(negedge clk);
        n_reset = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s edge%0d core_n_reset", tag, e), 64'(bus.core_n_reset), 64'(e == 6));
            chk($sformatf("%s edge%0d running", tag, e),      64'(bus.running),      64'(e == 6));
        end
    endtask

    initial begin
        segs[0] = '{10, 1'b1, 1'b1, 1'b1, 10, 10, 1'b0, 1'b0};
        segs[1] = '{10, 1'b0, 1'b0, 1'b1, 10, 10, 1'b0, 1'b0};
        segs[2] = '{ 5, 1'b1, 1'b1, 1'b0, 15, 10, 1'b0, 1'b0};
        segs[3] = '{27, 1'b1, 1'b1, 1'b1, 42, 37, 1'b0, 1'b0};
        segs[4] = '{ 8, 1'b1, 1'b1, 1'b0, 50, 37, 1'b0, 1'b0};
        segs[5] = '{ 5, 1'b1, 1'b0, 1'b0, 55, 37, 1'b0, 1'b0};
        segs[6] = '{ 2, 1'b0, 1'b0, 1'b0, 55, 37, 1'b0, 1'b0};
        segs[7] = '{ 7, 1'b1, 1'b0, 1'b0, 62, 37, 1'b1, 1'b1};
        segs[8] = '{ 3, 1'b1, 1'b1, 1'b1, 62, 37, 1'b1, 1'b1};

        // Halt: 20 advancing PCs, then a self-loop at 0x50
        reset_and_release("halt");
        for (int i = 0; i < 20; i++) step(1'b1, 32'(i * 4), 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 32'h0000_0050, 1'b0);
            if (i == 7) begin
                chk("halt early halted", 64'(bus.halted), 64'd0);
                chk("halt early done",   64'(bus.done),   64'd0);
            end
        end
        chk("halt halted",      64'(bus.halted),      64'd1);
        chk("halt done",        64'(bus.done),        64'd1);
        chk("halt timeout",     64'(bus.timeout),     64'd0);
        chk("halt running",     64'(bus.running),     64'd0);
        chk("halt cycle_count", 64'(bus.cycle_count), 64'd28);
        for (int i = 0; i < 4; i++) step(1'b1, 32'(256 + i * 4), 1'b1);
        chk("halt frozen cycle_count",  64'(bus.cycle_count),  64'd28);
        chk("halt frozen retire_count", 64'(bus.retire_count), 64'd0);
        chk("halt frozen core_n_reset", 64'(bus.core_n_reset), 64'd1);
        chk("halt frozen halted",       64'(bus.halted),       64'd1);

        // Timeout at MAX_CYCLES
        reset_and_release("timeout");
        for (int i = 1; i <= 199; i++) step(1'b1, 32'(i * 4), 1'b0);
        chk("timeout pre flag",        64'(bus.timeout),     64'd0);
        chk("timeout pre cycle_count", 64'(bus.cycle_count), 64'd199);
        chk("timeout pre running",     64'(bus.running),     64'd1);
        step(1'b1, 32'd800, 1'b0);
        chk("timeout flag",        64'(bus.timeout),     64'd1);
        chk("timeout done",        64'(bus.done),        64'd1);
        chk("timeout halted",      64'(bus.halted),      64'd0);
        chk("timeout cycle_count", 64'(bus.cycle_count), 64'd200);
        for (int i = 1; i <= 3; i++) step(1'b1, 32'(800 + i * 4), 1'b0);
        chk("timeout frozen cycle_count", 64'(bus.cycle_count), 64'd200);

        // Pause / retire / stall-clear segments
        reset_and_release("segs");
        for (int s = 0; s < 9; s++) begin
            for (int k = 0; k < segs[s].n; k++) begin
                if (segs[s].inc) pc_v = pc_v + 32'd4;
                step(segs[s].en, pc_v, segs[s].ret);
            end
            chk($sformatf("seg%0d cycle_count", s),  64'(bus.cycle_count),  64'(segs[s].exp_cyc));
            chk($sformatf("seg%0d retire_count", s), 64'(bus.retire_count), 64'(segs[s].exp_ret));
            chk($sformatf("seg%0d halted", s),       64'(bus.halted),       64'(segs[s].exp_halt));
            chk($sformatf("seg%0d done", s),         64'(bus.done),         64'(segs[s].exp_done));
            chk($sformatf("seg%0d running", s),      64'(bus.running),      64'(!segs[s].exp_done));
            chk($sformatf("seg%0d timeout", s),      64'(bus.timeout),      64'd0);
        end

        // Reset mid-run
        reset_and_release("midrun");
        for (int i = 1; i <= 30; i++) step(1'b1, 32'(i * 4), 1'b1);
        chk("midrun cycle_count",  64'(bus.cycle_count),  64'd30);
        chk("midrun retire_count", 64'(bus.retire_count), 64'd30);
        #4;
        n_reset = 1'b0;
        #1;
        check_idle("midrun async");
        reset_and_release("midrun release");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
